// File: rtl/fm_pkg.sv
// Shared types for the ALU issue controller: opcodes, ALU control encoding and FSM states.
package fm_pkg;

   localparam int DW = 8;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_INC  = 3'b010,
      OP_XOR  = 3'b011,
      OP_CMP  = 3'b100,
      OP_BZ   = 3'b101,
      OP_NOP0 = 3'b110,
      OP_NOP1 = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_INC = 2'd2,
      ALU_XOR = 2'd3
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_WB   = 3'd3,
      S_BR   = 3'd4
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational opcode decoder: ALU control plus writeback/flag/branch classification.
module op_decode
   import fm_pkg::*;
(
   input  logic [2:0] op,
   output alu_ctrl_t  alu_ctrl,
   output logic       writes_rd,
   output logic       sets_z,
   output logic       is_branch,
   output logic       is_nop
);

   // Decode table; CMP reuses the SUB datapath without writeback.
   always_comb begin
      alu_ctrl  = ALU_ADD;
      writes_rd = 1'b0;
      sets_z    = 1'b0;
      is_branch = 1'b0;
      is_nop    = 1'b0;
      case (opcode_t'(op))
         OP_ADD: begin
            alu_ctrl  = ALU_ADD;
            writes_rd = 1'b1;
         end
         OP_SUB: begin
            alu_ctrl  = ALU_SUB;
            writes_rd = 1'b1;
            sets_z    = 1'b1;
         end
         OP_INC: begin
            alu_ctrl  = ALU_INC;
            writes_rd = 1'b1;
         end
         OP_XOR: begin
            alu_ctrl  = ALU_XOR;
            writes_rd = 1'b1;
         end
         OP_CMP: begin
            alu_ctrl = ALU_SUB;
            sets_z   = 1'b1;
         end
         OP_BZ: begin
            is_branch = 1'b1;
         end
         OP_NOP0, OP_NOP1: begin
            is_nop = 1'b1;
         end
         default: begin
            is_nop = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller driving an 8-bit ALU: fetch operands, execute,
// write back and maintain the architectural zero flag used by BZ.
module alu_issue_ctrl #(
   parameter int NREG = 8,
   parameter int DW   = 8,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   input  logic [8:0]    instr,
   output logic          instr_ready,
   output logic [AW-1:0] rf_raddr_a,
   output logic [AW-1:0] rf_raddr_b,
   input  logic [DW-1:0] rf_rdata_a,
   input  logic [DW-1:0] rf_rdata_b,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_ctrl,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_z,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          z_flag,
   output logic          branch_taken,
   output logic [5:0]    branch_offset,
   output logic          done
);
   import fm_pkg::*;

   state_t        state_q, state_d;
   logic          ready_q, ready_d;
   logic [2:0]    op_q, op_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
   logic [DW-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
   alu_ctrl_t     ctrl_q, ctrl_d;
   logic          we_q, we_d, done_q, done_d, z_q, z_d, taken_q, taken_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [5:0]    off_q, off_d;

   logic [2:0]    op_sel;
   alu_ctrl_t     dec_ctrl;
   logic          dec_writes_rd, dec_sets_z, dec_is_branch, dec_is_nop;

   // In IDLE the incoming opcode picks the next state; later the latched one drives execution.
   assign op_sel = (state_q == S_IDLE) ? instr[8:6] : op_q;

   op_decode u_dec (
      .op        (op_sel),
      .alu_ctrl  (dec_ctrl),
      .writes_rd (dec_writes_rd),
      .sets_z    (dec_sets_z),
      .is_branch (dec_is_branch),
      .is_nop    (dec_is_nop)
   );

   // Next-state and next-output logic; pulses default low, everything else holds.
   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      op_d      = op_q;
      rd_d      = rd_q;
      raddr_a_d = raddr_a_q;
      raddr_b_d = raddr_b_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      res_d     = res_q;
      ctrl_d    = ctrl_q;
      waddr_d   = waddr_q;
      off_d     = off_q;
      z_d       = z_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
      taken_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d    = instr[8:6];
               rd_d    = instr[5:3];
               ready_d = 1'b0;
               if (dec_is_branch) begin
                  state_d = S_BR;
                  done_d  = 1'b1;
                  taken_d = z_q;
                  off_d   = instr[5:0];
               end else if (dec_is_nop) begin
                  state_d = S_WB;
                  done_d  = 1'b1;
               end else begin
                  state_d   = S_READ;
                  raddr_a_d = instr[5:3];
                  raddr_b_d = instr[2:0];
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            opa_d   = rf_rdata_a;
            opb_d   = rf_rdata_b;
            ctrl_d  = dec_ctrl;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu_result;
            waddr_d = rd_q;
            we_d    = dec_writes_rd;
            done_d  = 1'b1;
            if (dec_sets_z) begin
               z_d = alu_z;
            end else begin
               z_d = z_q;
            end
            state_d = S_WB;
         end
         S_WB, S_BR: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b1;
         op_q      <= 3'd0;
         rd_q      <= '0;
         raddr_a_q <= '0;
         raddr_b_q <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
         ctrl_q    <= ALU_ADD;
         waddr_q   <= '0;
         off_q     <= 6'd0;
         z_q       <= 1'b0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         taken_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         raddr_a_q <= raddr_a_d;
         raddr_b_q <= raddr_b_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         res_q     <= res_d;
         ctrl_q    <= ctrl_d;
         waddr_q   <= waddr_d;
         off_q     <= off_d;
         z_q       <= z_d;
         we_q      <= we_d;
         done_q    <= done_d;
         taken_q   <= taken_d;
      end
   end

   assign instr_ready   = ready_q;
   assign rf_raddr_a    = raddr_a_q;
   assign rf_raddr_b    = raddr_b_q;
   assign alu_a         = opa_q;
   assign alu_b         = opb_q;
   assign alu_ctrl      = ctrl_q;
   assign rf_we         = we_q;
   assign rf_waddr      = waddr_q;
   assign rf_wdata      = res_q;
   assign z_flag        = z_q;
   assign branch_taken  = taken_q;
   assign branch_offset = off_q;
   assign done          = done_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits on the driving side of the 8-bit ALU. It accepts one 9-bit instruction at a time over a valid/ready handshake and reads both operands from the register file. It drives the ALU operands and 2-bit control, then writes the result back and maintains the architectural zero flag used by conditional branches.

## Interface
Parameters:
- `NREG`, 8: register file depth; register addresses are `$clog2(NREG)` = 3 bits.
- `DW`, 8: datapath width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  9  `[8:6]` opcode, `[5:3]` rd, `[2:0]` rs; for BZ, `[5:0]` is the signed offset.
- `instr_ready`  out  1  high only in IDLE.
- `rf_raddr_a` / `rf_raddr_b`  out  3  register file read addresses (rd / rs).
- `rf_rdata_a` / `rf_rdata_b`  in  8  combinational read data.
- `alu_a` / `alu_b`  out  8  ALU operands (registered).
- `alu_ctrl`  out  2  0 ADD, 1 SUB, 2 INC, 3 XOR.
- `alu_result`  in  8  ALU result.
- `alu_z`  in  1  ALU zero output (meaningful only for SUB).
- `rf_we`  out  1  register write enable, one-cycle pulse.
- `rf_waddr`  out  3  write address (= rd).
- `rf_wdata`  out  8  write data.
- `z_flag`  out  1  architectural zero flag.
- `branch_taken`  out  1  one-cycle pulse; BZ with `z_flag` = 1.
- `branch_offset`  out  6  `instr[5:0]`, valid while `branch_taken` is high.
- `done`  out  1  one-cycle pulse at the retirement of every instruction.

## Operation
- Opcodes:
  - 000 ADD: rd = rd + rs.
  - 001 SUB: rd = rd − rs; updates `z_flag`.
  - 010 INC: rd = rd + 1.
  - 011 XOR: rd = rd ^ rs.
  - 100 CMP: SUB with no writeback; updates `z_flag`.
  - 101 BZ: branch on `z_flag`.
  - 110 and 111: NOP.
- All arithmetic is modulo 2^8; carry and borrow are discarded.
- Handshake: an instruction is accepted on an edge where `instr_valid & instr_ready` is high. The instruction is latched into `instr_q`. `instr` is don't-care otherwise.
- FSM states are IDLE, READ, EXEC, WB, BR.
  - IDLE: `instr_ready` = 1. On accept, go to BR for BZ, to WB for NOP, otherwise to READ.
  - READ: drive `rf_raddr_a/b` from `instr_q`; latch `rf_rdata_a/b` into `opa_q/opb_q`; go to EXEC.
  - EXEC: `alu_a` = `opa_q`, `alu_b` = `opb_q`, `alu_ctrl` from the opcode (CMP maps to 1). Latch `alu_result` into `res_q`. For SUB/CMP, latch `alu_z` into `z_flag`. Go to WB.
  - WB: `done` = 1. `rf_we` = 1 for ADD/SUB/INC/XOR only, with `rf_waddr` = rd and `rf_wdata` = `res_q`. Go to IDLE.
  - BR: `done` = 1, `branch_taken` = `z_flag`, `branch_offset` = `instr_q[5:0]`. Go to IDLE.
- `z_flag` is unchanged by ADD, INC, XOR, BZ and NOP.
- rd == rs is legal: both reads return the same value, and SUB then yields 0 with z = 1.
- Outputs outside their owning state:
  - `rf_we`, `done` and `branch_taken` are 0.
  - `alu_a`, `alu_b`, `alu_ctrl` and the read addresses hold their last values.

## Timing
- Reset values:
  - state = IDLE.
  - `instr_ready` = 1.
  - `rf_we`, `done`, `branch_taken`, `z_flag` = 0.
  - `alu_a`, `alu_b`, `rf_wdata`, `res_q` = 0.
  - `alu_ctrl`, the read/write addresses and `branch_offset` = 0.
- Reset asserted in any state aborts the instruction on that edge; no `rf_we` or `done` is issued for it.
- Cycle timing, with the instruction accepted at edge T:
  - ALU ops: READ is in cycle T+1, EXEC in T+2, WB in T+3 (`rf_we`/`done`). The next accept is at the earliest at edge T+4.
  - BZ and NOP: BR/WB is in cycle T+1. The next accept is at T+2.
- Back-to-back: a CMP retiring at T+3 makes `z_flag` visible to a BZ accepted at T+4. There is no forwarding hazard.
- `instr_valid` held high while busy is ignored; the instruction is accepted on the first IDLE edge.

## Structure
- Package `fm_pkg` holds:
  - `opcode_t` (3-bit enum).
  - `alu_ctrl_t` (ADD = 0, SUB = 1, INC = 2, XOR = 3), shared with the ALU.
  - `state_t` (IDLE, READ, EXEC, WB, BR).
  - `DW`.
- One sub-module, `op_decode`. It is combinational: opcode → `alu_ctrl`, `writes_rd`, `sets_z`, `is_branch`, `is_nop`.
- The FSM and the operand/result registers stay in the top.

## Test plan
- Reset, then r1 = 5, r2 = 3, ADD r1,r2 → `rf_we` pulse at T+3 with waddr 1, wdata 8; `z_flag` stays 0.
- SUB r1,r2 with r1 = r2 = 0x7F → wdata 0, `z_flag` = 1. Then ADD → `z_flag` still 1. Then CMP with 0x10, 0x20 → `z_flag` = 0 and no `rf_we`.
- INC with r4 = 0xFF → wdata 0x00 (wrap); `z_flag` unchanged.
- CMP equal operands, then BZ offset 6'h3A accepted at T+4 → `branch_taken` = 1 and `branch_offset` = 0x3A at T+5. Repeat after an unequal CMP → `branch_taken` = 0, `done` = 1.
- `instr_valid` held high with three queued instructions → accepts spaced 4 cycles apart; `instr_ready` = 0 in READ/EXEC/WB.
- Reset asserted in EXEC → no `rf_we`/`done`, `z_flag` = 0, and `instr_ready` = 1 on the next cycle.
